// File: rtl/nand_input_conditioner_pkg.sv
// Shared definitions for the NAND tile input path: conditioner state encoding,
// default timing parameters and operand bit indices.
package nand_tile_pkg;

   typedef enum logic [0:0] {
      STABLE   = 1'b0,
      SETTLING = 1'b1
   } cond_state_t;

   localparam int DEF_NBITS           = 2;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   localparam int OP_A = 0;
   localparam int OP_B = 1;

endpackage

// File: rtl/nand_input_conditioner_if.sv
// Pad-to-gate operand bundle: raw pad bits in, debounced levels and edge events out.
interface nand_input_conditioner_if #(
   parameter int NBITS = 2
);

   logic [NBITS-1:0] raw_in;
   logic [NBITS-1:0] clean_out;
   logic [NBITS-1:0] rise_pulse;
   logic [NBITS-1:0] fall_pulse;
   logic             settled;

   // The pad/tile side drives the raw bits and consumes the conditioned view.
   modport master (
      output raw_in,
      input  clean_out,
      input  rise_pulse,
      input  fall_pulse,
      input  settled
   );

   modport slave (
      input  raw_in,
      output clean_out,
      output rise_pulse,
      output fall_pulse,
      output settled
   );

endinterface

// File: rtl/nand_input_conditioner_debounce_bit.sv
// One conditioned input bit: synchroniser, settle counter and STABLE/SETTLING FSM,
// with registered one-cycle rise/fall events on each accepted level change.
module debounce_bit
   import nand_tile_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic stable
);

   localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [0:0]        S_STABLE   = STABLE;
   localparam logic [0:0]        S_SETTLING = SETTLING;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [0:0]             state;
   logic [CNT_W-1:0]       cnt;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign stable = (state == S_STABLE);

   // NOTE: all state is updated with non-blocking assignments so every flop
   // samples pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         clean  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         cnt    <= '0;
         state  <= S_STABLE;
      end else if (!ena) begin
         // Frozen tile: hold everything, but never repeat an event pulse.
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         rise   <= 1'b0;
         fall   <= 1'b0;
         cnt    <= '0;
         case (state)
            S_STABLE: begin
               if (sync != clean) state <= S_SETTLING;
            end
            S_SETTLING: begin
               if (sync == clean) begin
                  state <= S_STABLE;
               end else if (cnt == CNT_LAST) begin
                  clean <= sync;
                  rise  <= sync;
                  fall  <= ~sync;
                  state <= S_STABLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= S_STABLE;
         endcase
      end
   end

endmodule

// File: rtl/nand_input_conditioner.sv
// NAND tile input conditioner: NBITS independent debounced operand bits plus
// an aggregate settled flag for the status logic.
module nand_input_conditioner
   import nand_tile_pkg::*;
#(
   parameter int NBITS           = DEF_NBITS,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input logic                      clk,
   input logic                      rst_n,
   input logic                      ena,
   nand_input_conditioner_if.slave  bus
);

   logic [NBITS-1:0] clean_vec;
   logic [NBITS-1:0] rise_vec;
   logic [NBITS-1:0] fall_vec;
   logic [NBITS-1:0] stable_vec;

   for (genvar i = 0; i < NBITS; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .ena    (ena),
         .raw    (bus.raw_in[i]),
         .clean  (clean_vec[i]),
         .rise   (rise_vec[i]),
         .fall   (fall_vec[i]),
         .stable (stable_vec[i])
      );
   end

   assign bus.clean_out  = clean_vec;
   assign bus.rise_pulse = rise_vec;
   assign bus.fall_pulse = fall_vec;
   // Pure reduction over state flops; raw_in has no path to any output.
   assign bus.settled    = &stable_vec;

endmodule

// File: tb/tb_nand_input_conditioner.sv
// Self-checking bench for nand_input_conditioner: directed vector table, corner
// sequences and randomized traffic against a run-length reference model.
module tb_nand_input_conditioner;
   import nand_tile_pkg::*;

   localparam int NB   = 2;
   localparam int SYNC = 2;
   localparam int DEB  = 4;

   typedef struct {
      logic          rst_n;
      logic          ena;
      logic [NB-1:0] raw;
      logic [NB-1:0] exp_clean;
      logic [NB-1:0] exp_rise;
      logic [NB-1:0] exp_fall;
      logic          exp_settled;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ena;

   int n_cmp  = 0;
   int n_fail = 0;

   nand_input_conditioner_if #(.NBITS(NB)) pins ();

   nand_input_conditioner #(
      .NBITS           (NB),
      .SYNC_STAGES     (SYNC),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (pins)
   );

   always #5 clk = ~clk;

   // Reference model: the synchroniser is a plain delay line of raw samples, and a
   // bit is accepted once its synchronised value has disagreed with the clean level
   // on DEB+1 consecutive enabled edges (one edge to notice, DEB to settle).
   logic [NB-1:0] m_q[$];
   logic [NB-1:0] m_clean, m_rise, m_fall;
   int            m_run[NB];

   function automatic void model_reset();
      m_q = {};
      for (int k = 0; k < SYNC; k++) m_q.push_back('0);
      m_clean = '0;
      m_rise  = '0;
      m_fall  = '0;
      for (int k = 0; k < NB; k++) m_run[k] = 0;
   endfunction

   function automatic void model_edge(logic r, logic e, logic [NB-1:0] raw);
      logic [NB-1:0] s;
      if (!r) begin
         model_reset();
      end else if (!e) begin
         m_rise = '0;
         m_fall = '0;
      end else begin
         s = m_q.pop_front();
         m_q.push_back(raw);
         m_rise = '0;
         m_fall = '0;
         for (int k = 0; k < NB; k++) begin
            if (s[k] != m_clean[k]) begin
               m_run[k]++;
               if (m_run[k] == DEB + 1) begin
                  m_clean[k] = s[k];
                  if (s[k]) m_rise[k] = 1'b1;
                  else      m_fall[k] = 1'b1;
                  m_run[k] = 0;
               end
            end else begin
               m_run[k] = 0;
            end
         end
      end
   endfunction

   function automatic logic model_settled();
      for (int k = 0; k < NB; k++) if (m_run[k] != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One rising edge with the currently driven inputs; outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_edge(rst_n, ena, pins.raw_in);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".clean"},   32'(pins.clean_out),  32'(m_clean));
      check({tag, ".rise"},    32'(pins.rise_pulse), 32'(m_rise));
      check({tag, ".fall"},    32'(pins.fall_pulse), 32'(m_fall));
      check({tag, ".settled"}, 32'(pins.settled),    32'(model_settled()));
   endtask

   vec_t tbl[$];

   function automatic void add_vec(logic r, logic e, logic [NB-1:0] raw, logic [NB-1:0] c,
                                   logic [NB-1:0] rs, logic [NB-1:0] fl, logic st);
      vec_t v;
      v.rst_n = r; v.ena = e; v.raw = raw;
      v.exp_clean = c; v.exp_rise = rs; v.exp_fall = fl; v.exp_settled = st;
      tbl.push_back(v);
   endfunction

   // A held change: two sync edges, four settling edges, acceptance on the 7th, then quiet.
   function automatic void add_change(logic [NB-1:0] raw, logic [NB-1:0] from, logic [NB-1:0] to,
                                      logic [NB-1:0] rs, logic [NB-1:0] fl);
      for (int k = 0; k < 2; k++) add_vec(1, 1, raw, from, 0, 0, 1);
      for (int k = 0; k < 4; k++) add_vec(1, 1, raw, from, 0, 0, 0);
      add_vec(1, 1, raw, to, rs, fl, 1);
      add_vec(1, 1, raw, to, 0, 0, 1);
   endfunction

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      pins.raw_in = '0;
      model_reset();

      // Directed table: reset with pads high, clean rise on A, rise on B, simultaneous fall.
      add_vec(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
      add_vec(0, 1, 2'b11, 2'b00, 2'b00, 2'b00, 1);
      add_vec(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add_vec(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add_change(2'b01, 2'b00, 2'b01, 2'b01, 2'b00);
      add_change(2'b11, 2'b01, 2'b11, 2'b10, 2'b00);
      add_change(2'b00, 2'b11, 2'b00, 2'b00, 2'b11);

      for (int n = 0; n < tbl.size(); n++) begin
         rst_n       = tbl[n].rst_n;
         ena         = tbl[n].ena;
         pins.raw_in = tbl[n].raw;
         step();
         check($sformatf("tbl[%0d].clean", n),   32'(pins.clean_out),  32'(tbl[n].exp_clean));
         check($sformatf("tbl[%0d].rise", n),    32'(pins.rise_pulse), 32'(tbl[n].exp_rise));
         check($sformatf("tbl[%0d].fall", n),    32'(pins.fall_pulse), 32'(tbl[n].exp_fall));
         check($sformatf("tbl[%0d].settled", n), 32'(pins.settled),    32'(tbl[n].exp_settled));
      end

      // Bounce on B: high for 3 edges reaches SETTLING but reverts before acceptance.
      for (int e = 1; e <= 9; e++) begin
         pins.raw_in = '0;
         if (e <= 3) pins.raw_in[OP_B] = 1'b1;
         step();
         check_model("bounce");
         if (e == 3) check("bounce.entered_settling", 32'(pins.settled), 32'd0);
      end
      check("bounce.clean_final",   32'(pins.clean_out), 32'd0);
      check("bounce.settled_final", 32'(pins.settled),   32'd1);

      // ena low for 5 edges mid-settle: acceptance moves from edge 7 to edge 12.
      pins.raw_in = '0;
      pins.raw_in[OP_A] = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         ena = !(e >= 5 && e <= 9);
         step();
         check_model("ena");
         if (!ena)   check("ena.no_pulse", 32'({pins.rise_pulse, pins.fall_pulse}), 32'd0);
         if (e == 11) check("ena.not_yet", 32'(pins.clean_out), 32'd0);
         if (e == 12) begin
            check("ena.accept_clean", 32'(pins.clean_out),  32'b01);
            check("ena.accept_rise",  32'(pins.rise_pulse), 32'b01);
         end
      end
      ena = 1'b1;
      pins.raw_in = '0;
      for (int e = 1; e <= 8; e++) begin
         step();
         check_model("ena_return");
      end

      // Reset on the 5th edge after a change on B aborts the settle without a pulse.
      pins.raw_in = 2'b10;
      for (int e = 1; e <= 5; e++) begin
         rst_n = (e != 5);
         step();
         check_model("rst_mid");
      end
      check("rst_mid.clean",   32'(pins.clean_out),                        32'd0);
      check("rst_mid.pulses",  32'({pins.rise_pulse, pins.fall_pulse}),   32'd0);
      check("rst_mid.settled", 32'(pins.settled),                          32'd1);
      rst_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         step();
         check_model("rst_resettle");
      end

      // Randomized traffic: sparse raw changes, occasional ena drops and resets.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 5) == 0) pins.raw_in = NB'($urandom_range(0, 3));
         ena   = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 199) != 0);
         step();
         check_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/nand_input_conditioner.md
Name: nand_input_conditioner

Overview:
- Upstream stage of the NAND gate tile; sits between the raw `ui_in[1:0]` pad bits and the gate's A/B operands.
- Per bit: synchronises the asynchronous pad input, debounces it with a per-bit settle counter and FSM, and presents a clean level to the gate.
- Also emits one-cycle rise/fall event pulses, used by the status/LED logic on spare `uo_out` bits.

Parameters:
- NBITS, 2, number of conditioned input bits (bit 0 = A, bit 1 = B).
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; legal range 2..3.
- DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before it is accepted; minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), settle counter width; derived, not overridden.

Ports:
- clk  input  1  tile clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ena  input  1  tile enable; 0 freezes all state.
- raw_in  input  NBITS  asynchronous pad bits (`ui_in[NBITS-1:0]`).
- clean_out  output  NBITS  debounced levels, fed to the NAND operands.
- rise_pulse  output  NBITS  one-cycle pulse per bit on an accepted 0->1 change.
- fall_pulse  output  NBITS  one-cycle pulse per bit on an accepted 1->0 change.
- settled  output  1  1 when every bit's FSM is in STABLE.

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is synchronous and active-low, sampled only on the rising edge of `clk`.
- Reset (`rst_n`=0 at an edge), applied to all state:
  - synchroniser flops = 0
  - clean_out = 0
  - rise_pulse = 0, fall_pulse = 0
  - all counters = 0
  - all FSMs = STABLE, so settled = 1
- Reset asserted mid-settle aborts the settle. No pulse is produced.
- ena = 0: synchroniser, counters, FSMs and clean_out all hold their values; rise_pulse and fall_pulse are forced to 0. Reset has priority over ena.
- Synchroniser: a SYNC_STAGES-deep shift register per bit. `sync[i]` is the last stage.
- Per-bit FSM has two states:
  - STABLE:
    - If `sync[i] != clean_out[i]`: go to SETTLING, cnt = 0.
    - Otherwise hold, cnt = 0.
  - SETTLING:
    - If `sync[i] == clean_out[i]` (bounce back): go to STABLE, cnt = 0, no pulse.
    - Else if cnt == DEBOUNCE_CYCLES-1: `clean_out[i] <= sync[i]`, pulse the matching rise_pulse[i] or fall_pulse[i] for exactly one cycle, go to STABLE, cnt = 0.
    - Else cnt = cnt + 1.
- Latency:
  - A raw change held stable appears on clean_out after the (SYNC_STAGES + DEBOUNCE_CYCLES + 1)th rising edge following the change. With defaults this is the 19th edge.
  - The pulse is registered and is high in the same cycle that clean_out first shows the new value.
- Glitch rejection:
  - Any glitch that reverts before acceptance produces no output change.
  - A glitch shorter than SYNC_STAGES cycles may never reach SETTLING.
- Bits are fully independent. Simultaneous changes on A and B settle in parallel, and both pulses may be high in the same cycle.
- A new change that arrives while a bit is SETTLING toward the opposite level can only be the match case, which returns the bit to STABLE. The counter never wraps.
- settled = AND over all bits of (state == STABLE). It is combinational from state registers only.
- All outputs are driven from registers, or from pure logic on registers. There are no paths from raw_in to any output.

Decomposition:
- Shared package `nand_tile_pkg`:
  - state enum `cond_state_t {STABLE, SETTLING}`
  - localparam defaults for SYNC_STAGES and DEBOUNCE_CYCLES
  - NBITS = 2 operand-index constants OP_A = 0, OP_B = 1
- One sub-module `debounce_bit` holds the single-bit synchroniser, counter and FSM. The top instantiates NBITS copies in a generate loop and ANDs their stable flags.

Test Plan (bench overrides DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2):
- Reset: hold rst_n = 0 for 2 edges with raw_in = 2'b11 -> clean_out = 2'b00, both pulse vectors = 0, settled = 1.
- Clean rise: raw_in 00->01 and held -> clean_out[0] = 1 after the 7th edge; rise_pulse = 2'b01 for exactly that one cycle; settled = 0 from the 3rd through the 7th edge.
- Bounce: raw_in[1] high for 3 cycles, then low -> clean_out stays 2'b00, no pulses, settled returns to 1.
- Simultaneous fall: from clean 2'b11, raw_in -> 00 -> after the 7th edge clean_out = 00 and fall_pulse = 2'b11 in the same cycle.
- ena gating: drop ena to 0 for 5 cycles mid-settle, then back to 1 -> acceptance is delayed by exactly 5 cycles; pulses are 0 while ena = 0.
- Reset mid-settle: rst_n = 0 at the 5th edge after a raw change -> clean_out = 0, no pulse, FSM back in STABLE.
